// File: rtl/sine_arbiter.sv
// sine_arbiter: round-robin sequencer sharing one sine_approx among NUM_REQ requesters.
// Optional input saturation and error flag via SINE_ARB_RANGE_CHECK_EN.
module sine_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW = $clog2(NUM_REQ),
  parameter int TOTAL_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*TOTAL_WIDTH-1:0] req_x,
  output logic [TOTAL_WIDTH-1:0]         sin_x,
  input  logic [TOTAL_WIDTH-1:0]         sin_y,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [TOTAL_WIDTH-1:0]         rsp_y,
  output logic [IDW-1:0]                 rsp_id,
  output logic                           rsp_err
);
  localparam int W = TOTAL_WIDTH;
  localparam logic [1:0] IDLE = 2'd0, EVAL = 2'd1, RESP = 2'd2;
  logic [1:0] state_q, state_d;
  logic [IDW-1:0] rr_q, rr_d, id_q, id_d, rsp_id_q, rsp_id_d, win;
  logic [W-1:0] x_q, x_d, rsp_y_q, rsp_y_d, x_sel, x_in;
  logic found, rsp_valid_q, rsp_valid_d;
  // Scan downward from the farthest offset so the nearest valid requester wins.
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        win = IDW'((int'(rr_q) + k) % NUM_REQ);
      end
    end
  end
  assign x_sel = req_x[int'(win)*W +: W];
`ifdef SINE_ARB_RANGE_CHECK_EN
  localparam logic signed [W-1:0] X_MIN = W'(-101), X_MAX = W'(100);
  logic err_in, err_q, err_d, rsp_err_q, rsp_err_d;
  assign err_in = $signed(x_sel) < X_MIN || $signed(x_sel) > X_MAX;
  assign x_in = err_in ? ($signed(x_sel) < X_MIN ? X_MIN : X_MAX) : x_sel;
  assign rsp_err = rsp_err_q;
`else
  assign x_in = x_sel;
  assign rsp_err = 1'b0;
`endif
  assign req_ready = (!rst && state_q == IDLE && found) ? NUM_REQ'(1) << win : '0;
  assign sin_x = x_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y = rsp_y_q;
  assign rsp_id = rsp_id_q;
  always_comb begin
    state_d = state_q;
    rr_d = rr_q;
    x_d = x_q;
    id_d = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_y_d = rsp_y_q;
    rsp_id_d = rsp_id_q;
`ifdef SINE_ARB_RANGE_CHECK_EN
    err_d = err_q;
    rsp_err_d = rsp_err_q;
`endif
    if (state_q == IDLE && found) begin
      state_d = EVAL;
      x_d = x_in;
      id_d = win;
      rr_d = IDW'((int'(win) + 1) % NUM_REQ);
`ifdef SINE_ARB_RANGE_CHECK_EN
      err_d = err_in;
`endif
    end else if (state_q == EVAL) begin
      state_d = RESP;
      rsp_y_d = sin_y;
      rsp_id_d = id_q;
      rsp_valid_d = 1'b1;
`ifdef SINE_ARB_RANGE_CHECK_EN
      rsp_err_d = err_q;
`endif
    end else if (state_q == RESP && rsp_ready) begin
      state_d = IDLE;
      rsp_valid_d = 1'b0;
    end else if (state_q > RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q <= '0;
      x_q <= '0;
      id_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_y_q <= '0;
      rsp_id_q <= '0;
`ifdef SINE_ARB_RANGE_CHECK_EN
      err_q <= 1'b0;
      rsp_err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      x_q <= x_d;
      id_q <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q <= rsp_y_d;
      rsp_id_q <= rsp_id_d;
`ifdef SINE_ARB_RANGE_CHECK_EN
      err_q <= err_d;
      rsp_err_q <= rsp_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_sine_arbiter.sv
// tb_sine_arbiter: directed table plus randomized transactions against a round-robin reference model.
module tb_sine_arbiter;
  logic clk = 1'b0, rst, rsp_valid, rsp_ready, rsp_err;
  logic [3:0] req_valid, req_ready;
  logic [31:0] req_x;
  logic [7:0] sin_x, sin_y, rsp_y;
  logic [1:0] rsp_id;
  int checks = 0, failures = 0, mp = 0;
  typedef struct {logic [3:0] v; logic [31:0] x; int hold; int id; logic [7:0] sx; logic err;} vec_t;
  vec_t tbl[16];

  sine_arbiter #(.NUM_REQ(4)) dut (.clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .sin_x(sin_x), .sin_y(sin_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_id(rsp_id), .rsp_err(rsp_err));

  always #5 clk = ~clk;

  // Stand-in for the external sine_approx: round(16*sin(x/16)) in S3.4.
  function automatic logic [7:0] sine_model(input logic signed [7:0] x);
    real r;
    r = $sin($itor(x) / 16.0) * 16.0;
    return 8'($rtoi(r >= 0.0 ? r + 0.5 : r - 0.5));
  endfunction
  assign sin_y = sine_model(sin_x);

  function automatic logic [7:0] exp_sx(input logic signed [7:0] x);
`ifdef SINE_ARB_RANGE_CHECK_EN
    return x < -101 ? 8'h9B : x > 100 ? 8'h64 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic exp_err(input logic signed [7:0] x);
`ifdef SINE_ARB_RANGE_CHECK_EN
    return x < -101 || x > 100;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction starting in IDLE; the grant is expected in the current cycle.
  task automatic txn(input logic [3:0] v, input logic [31:0] x, input int hold, input int ew,
                     input logic [7:0] esx, input logic ee);
    logic [7:0] ey;
    ey = sine_model(esx);
    req_valid = v;
    req_x = x;
    rsp_ready = 1'b0;
    #1;
    if (v == 4'd0) begin
      chk("idle_no_ready", req_ready, 0);
      tick();
      chk("idle_no_rsp", rsp_valid, 0);
      return;
    end
    chk("grant", req_ready, 32'(4'b1 << ew));
    tick();
    req_valid = 4'd0;
    #1;
    chk("eval_sin_x", sin_x, esx);
    chk("eval_ready", req_ready, 0);
    chk("eval_rsp_valid", rsp_valid, 0);
    tick();
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_y", rsp_y, ey);
    chk("rsp_id", rsp_id, ew);
    chk("rsp_err", rsp_err, ee);
    for (int i = 0; i < hold; i++) begin
      req_valid = v;
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_y", rsp_y, ey);
      chk("hold_id", rsp_id, ew);
      chk("hold_err", rsp_err, ee);
      chk("hold_ready", req_ready, 0);
    end
    req_valid = 4'd0;
    rsp_ready = 1'b1;
    tick();
    chk("release", rsp_valid, 0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    tbl[0]  = '{4'hF, 32'hE0F0_2010, 0, 0, 8'h10, 1'b0};
    tbl[1]  = '{4'hF, 32'hE0F0_2010, 0, 1, 8'h20, 1'b0};
    tbl[2]  = '{4'hF, 32'hE0F0_2010, 0, 2, 8'hF0, 1'b0};
    tbl[3]  = '{4'hF, 32'hE0F0_2010, 0, 3, 8'hE0, 1'b0};
    tbl[4]  = '{4'h1, 32'h0000_0000, 0, 0, 8'h00, 1'b0};
    tbl[5]  = '{4'h4, 32'h0030_0000, 10, 2, 8'h30, 1'b0};
    tbl[6]  = '{4'hA, 32'hF800_0800, 0, 3, 8'hF8, 1'b0};
    tbl[7]  = '{4'hA, 32'hF800_0800, 0, 1, 8'h08, 1'b0};
    tbl[8]  = '{4'hA, 32'hF800_0800, 0, 3, 8'hF8, 1'b0};
    tbl[9]  = '{4'hA, 32'hF800_0800, 0, 1, 8'h08, 1'b0};
`ifdef SINE_ARB_RANGE_CHECK_EN
    tbl[10] = '{4'h1, 32'h0000_0078, 0, 0, 8'h64, 1'b1};
    tbl[11] = '{4'h2, 32'h0000_8000, 0, 1, 8'h9B, 1'b1};
`else
    tbl[10] = '{4'h1, 32'h0000_0078, 0, 0, 8'h78, 1'b0};
    tbl[11] = '{4'h2, 32'h0000_8000, 0, 1, 8'h80, 1'b0};
`endif
    tbl[12] = '{4'h4, 32'h0064_0000, 0, 2, 8'h64, 1'b0};
    tbl[13] = '{4'h8, 32'h9B00_0000, 0, 3, 8'h9B, 1'b0};
    tbl[14] = '{4'h0, 32'h1234_5678, 0, 0, 8'h00, 1'b0};
    tbl[15] = '{4'h6, 32'h0040_C000, 2, 1, 8'hC0, 1'b0};
    rst = 1'b1;
    req_valid = 4'hF;
    req_x = 32'h1122_3344;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("rst_ready", req_ready, 0);
    rst = 1'b0;
    req_valid = 4'd0;
    tick();
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_sin_x", sin_x, 0);
    chk("rst_rsp_y", rsp_y, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_err", rsp_err, 0);
    for (int i = 0; i < 16; i++) begin
      txn(tbl[i].v, tbl[i].x, tbl[i].hold, tbl[i].id, tbl[i].sx, tbl[i].err);
      if (tbl[i].v != 4'd0) mp = (tbl[i].id + 1) % 4;
    end
    // Reset while a request is being evaluated: no response may follow, pointer returns to 0.
    req_valid = 4'h4;
    req_x = 32'h0020_0000;
    tick();
    req_valid = 4'h1;
    rst = 1'b1;
    #1;
    chk("abort_ready_in_rst", req_ready, 0);
    tick();
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_sin_x", sin_x, 0);
    rst = 1'b0;
    req_valid = 4'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_rsp", rsp_valid, 0);
    end
    mp = 0;
    for (int n = 0; n < 40; n++) begin
      logic [3:0] v;
      logic [31:0] x;
      int w;
      v = 4'($urandom_range(0, 15));
      x = $urandom;
      w = -1;
      for (int k = 0; k < 4 && w < 0; k++)
        if (v[(mp + k) % 4]) w = (mp + k) % 4;
      if (w < 0) txn(v, x, 0, 0, 8'h00, 1'b0);
      else begin
        txn(v, x, $urandom_range(0, 3), w, exp_sx(x[w*8 +: 8]), exp_err(x[w*8 +: 8]));
        mp = (w + 1) % 4;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
